// File: rtl/fir_64_mdc_kernel_adapter_if.sv
// Valid/ready stream interface carrying samples between the HWPE streamer and the adapter.
// The sink modport receives data; the source modport produces it.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/fir_64_mdc_kernel_adapter.sv
// Bridges HWPE streams to an HLS FIR kernel's AXI-stream ports and sequences one job of len_i samples.
// Handshakes pass straight through while running, gated by the per-job sample budget.
module fir_64_mdc_kernel_adapter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    hwpe_stream_intf_stream.sink   x_V,
    hwpe_stream_intf_stream.source y_V,
    output logic [DATA_WIDTH-1:0] kx_tdata_o,
    output logic                  kx_tvalid_o,
    input  logic                  kx_tready_i,
    input  logic [DATA_WIDTH-1:0] ky_tdata_i,
    input  logic                  ky_tvalid_i,
    output logic                  ky_tready_o,
    output logic                  ap_start_o,
    input  logic                  ap_done_i,
    input  logic                  ap_idle_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  in_cnt_o,
    output logic [CNT_WIDTH-1:0]  out_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_AP,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ap_start_q, ap_start_d;

    logic run_act;
    logic in_room;
    logic out_room;
    logic in_hs;
    logic out_hs;

    // The budget comparisons stop each direction once len samples have moved.
    assign run_act  = enable_i && (state_q == RUN);
    assign in_room  = in_cnt_q < len_q;
    assign out_room = out_cnt_q < len_q;

    assign kx_tdata_o  = x_V.data;
    assign kx_tvalid_o = run_act && x_V.valid && in_room;
    assign x_V.ready   = run_act && kx_tready_i && in_room;
    assign in_hs       = kx_tvalid_o && kx_tready_i;

    assign y_V.data    = ky_tdata_i;
    assign y_V.strb    = '1;
    assign y_V.valid   = run_act && ky_tvalid_i && out_room;
    assign ky_tready_o = run_act && y_V.ready && out_room;
    assign out_hs      = y_V.valid && y_V.ready;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        done_d    = done_q;

        if (clear_i) begin
            state_d   = IDLE;
            len_d     = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            err_d     = 1'b0;
            done_d    = 1'b0;
        end else if (enable_i) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            len_d     = len_i;
                            in_cnt_d  = '0;
                            out_cnt_d = '0;
                            err_d     = 1'b0;
                            state_d   = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (ky_tvalid_i && !out_room) begin
                        err_d = 1'b1;
                    end
                    if (in_hs) begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                    if (out_hs) begin
                        out_cnt_d = out_cnt_q + 1'b1;
                        if (out_cnt_d == len_q) begin
                            state_d = WAIT_AP;
                        end
                    end
                end
                WAIT_AP: begin
                    if (ky_tvalid_i) begin
                        err_d = 1'b1;
                    end
                    if (ap_done_i || ap_idle_i) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    if (ky_tvalid_i) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d     = (state_d == RUN) || (state_d == WAIT_AP);
        ap_start_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            len_q      <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ap_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ap_start_q <= ap_start_d;
        end
    end

    assign ap_start_o = ap_start_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign in_cnt_o   = in_cnt_q;
    assign out_cnt_o  = out_cnt_q;

endmodule

// File: tb/tb_fir_64_mdc_kernel_adapter.sv
// Bench for the FIR kernel adapter: an echoing kernel model, a job-level reference model and
// a scoreboard of accepted samples, checked every cycle with immediate assertions.
module tb_fir_64_mdc_kernel_adapter;

    localparam int DW = 32;
    localparam int CW = 32;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          enable;
    logic          clear;
    logic          start;
    logic [CW-1:0] len;
    logic [DW-1:0] kx_tdata;
    logic          kx_tvalid;
    logic          kx_tready;
    logic [DW-1:0] ky_tdata;
    logic          ky_tvalid;
    logic          ky_tready;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) x_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) y_if ();

    fir_64_mdc_kernel_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .clear_i     (clear),
        .start_i     (start),
        .len_i       (len),
        .x_V         (x_if.sink),
        .y_V         (y_if.source),
        .kx_tdata_o  (kx_tdata),
        .kx_tvalid_o (kx_tvalid),
        .kx_tready_i (kx_tready),
        .ky_tdata_i  (ky_tdata),
        .ky_tvalid_i (ky_tvalid),
        .ky_tready_o (ky_tready),
        .ap_start_o  (ap_start),
        .ap_done_i   (ap_done),
        .ap_idle_i   (ap_idle),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .in_cnt_o    (in_cnt),
        .out_cnt_o   (out_cnt)
    );

    int tests  = 0;
    int failed = 0;

    // Kernel model: every accepted input sample reappears on the output one cycle later, in order.
    logic [DW-1:0] kq[$];
    bit            force_ky = 1'b0;
    bit            flush_k  = 1'b0;
    bit            k_has    = 1'b0;
    logic [DW-1:0] k_front  = '0;
    bit            k_push;
    bit            k_pop;
    logic [DW-1:0] k_data;

    assign ky_tvalid = force_ky || k_has;
    assign ky_tdata  = k_front;

    always @(posedge clk) begin
        k_push = kx_tvalid && kx_tready;
        k_pop  = ky_tvalid && ky_tready;
        k_data = kx_tdata;
        #1;
        if (flush_k) begin
            kq.delete();
        end else begin
            if (k_pop && kq.size() > 0) void'(kq.pop_front());
            if (k_push) kq.push_back(k_data);
        end
        k_has   = kq.size() > 0;
        k_front = (kq.size() > 0) ? kq[0] : 32'hDEAD_BEEF;
    end

    // Reference model of the job, advanced once per clock edge.
    int            m_phase = P_IDLE;
    int unsigned   m_len   = 0;
    int unsigned   m_in    = 0;
    int unsigned   m_out   = 0;
    bit            m_err   = 1'b0;
    bit            m_done  = 1'b0;
    logic [DW-1:0] sb_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit st, input bit clr, input int unsigned ln,
                                 input bit xv, input bit kr, input bit yr, input bit ad);
        enable     = en;
        start      = st;
        clear      = clr;
        len        = ln;
        x_if.valid = xv;
        x_if.data  = $urandom;
        kx_tready  = kr;
        y_if.ready = yr;
        ap_done    = ad;
    endtask

    task automatic modelReset();
        m_phase = P_IDLE;
        m_len   = 0;
        m_in    = 0;
        m_out   = 0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        sb_q.delete();
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic stepCycle();
        bit            act;
        bit            hs_in;
        bit            hs_out;
        bit            ky;
        logic [DW-1:0] xd;
        #1;
        act    = enable && (m_phase == P_RUN);
        hs_in  = act && x_if.valid && kx_tready && (m_in < m_len);
        hs_out = act && ky_tvalid && y_if.ready && (m_out < m_len);
        checkOutput("kx_tvalid", kx_tvalid, act && x_if.valid && (m_in < m_len));
        checkOutput("x_ready", x_if.ready, act && kx_tready && (m_in < m_len));
        checkOutput("y_valid", y_if.valid, act && ky_tvalid && (m_out < m_len));
        checkOutput("ky_tready", ky_tready, act && y_if.ready && (m_out < m_len));
        checkOutput("kx_tdata", kx_tdata, x_if.data);
        checkOutput("ap_start", ap_start, m_phase == P_RUN);
        checkOutput("busy", busy, (m_phase == P_RUN) || (m_phase == P_WAIT));
        checkOutput("done", done, m_done);
        checkOutput("err", err, m_err);
        checkOutput("in_cnt", in_cnt, m_in);
        checkOutput("out_cnt", out_cnt, m_out);
        if (hs_out && sb_q.size() > 0) checkOutput("y_data", y_if.data, sb_q[0]);
        ky = ky_tvalid;
        xd = x_if.data;
        @(posedge clk);
        if (clear) begin
            modelReset();
        end else if (enable) begin
            m_done = 1'b0;
            case (m_phase)
                P_IDLE: if (start) begin
                    if (len != 0) begin
                        m_len   = len;
                        m_in    = 0;
                        m_out   = 0;
                        m_err   = 1'b0;
                        m_phase = P_RUN;
                    end else begin
                        m_done = 1'b1;
                    end
                end
                P_RUN: begin
                    if (ky && m_out >= m_len) m_err = 1'b1;
                    if (hs_in) begin
                        m_in++;
                        sb_q.push_back(xd);
                    end
                    if (hs_out) begin
                        m_out++;
                        if (sb_q.size() > 0) void'(sb_q.pop_front());
                        if (m_out == m_len) m_phase = P_WAIT;
                    end
                end
                P_WAIT: begin
                    if (ky) m_err = 1'b1;
                    if (ap_done || ap_idle) begin
                        m_phase = P_DONE;
                        m_done  = 1'b1;
                    end
                end
                default: begin
                    if (ky) m_err = 1'b1;
                    m_phase = P_IDLE;
                end
            endcase
        end
        #2;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        flush_k = 1'b1;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ap_start", ap_start, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_in_cnt", in_cnt, 0);
        checkOutput("rst_out_cnt", out_cnt, 0);
        checkOutput("rst_x_ready", x_if.ready, 0);
        checkOutput("rst_y_valid", y_if.valid, 0);
        checkOutput("rst_kx_tvalid", kx_tvalid, 0);
        checkOutput("rst_ky_tready", ky_tready, 0);
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        flush_k = 1'b0;
        modelReset();
    endtask

    int unsigned saved_in;
    int unsigned saved_out;
    int unsigned rlen;

    initial begin
        rst_n   = 1'b0;
        ap_idle = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        doReset();
        stepCycle();

        // Four-sample job with an always-ready path, finished by ap_done.
        applyStimulus(1, 1, 0, 4, 1, 1, 1, 0);
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 40 && m_phase != P_WAIT; i++) begin
            x_if.data = $urandom;
            stepCycle();
        end
        #1;
        checkOutput("s1_in_cnt", in_cnt, 4);
        checkOutput("s1_out_cnt", out_cnt, 4);
        checkOutput("s1_wait_busy", {busy, ap_start}, 2'b10);
        checkOutput("y_strb", y_if.strb, 4'hF);
        ap_done = 1'b1;
        stepCycle();
        ap_done = 1'b0;
        stepCycle();
        stepCycle();

        // Zero-length job completes immediately without becoming busy.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();

        // Three-sample job with a fourth input offered and the output stalled.
        applyStimulus(1, 1, 0, 3, 1, 1, 0, 0);
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 6; i++) stepCycle();
        #1;
        checkOutput("s3_x_ready_4th", x_if.ready, 0);
        checkOutput("s3_in_cnt", in_cnt, 3);
        y_if.ready = 1'b1;
        for (int i = 0; i < 20 && m_phase != P_WAIT; i++) stepCycle();
        ap_idle = 1'b1;
        stepCycle();
        ap_idle = 1'b0;
        stepCycle();
        stepCycle();

        // Stray kernel output after the job has drained raises the sticky error.
        applyStimulus(1, 1, 0, 2, 1, 1, 1, 0);
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 20 && m_phase != P_WAIT; i++) stepCycle();
        force_ky = 1'b1;
        stepCycle();
        force_ky = 1'b0;
        stepCycle();
        ap_done = 1'b1;
        stepCycle();
        ap_done = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle();
        #1;
        checkOutput("s4_err_sticky", err, 1);

        // Next start clears the error; the job is frozen for five cycles mid-run.
        applyStimulus(1, 1, 0, 6, 1, 1, 0, 0);
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle();
        saved_in  = m_in;
        saved_out = m_out;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, $urandom_range(0, 1), 0, 6, $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 1), 0);
            stepCycle();
        end
        #1;
        checkOutput("s5_frozen_in", in_cnt, saved_in);
        checkOutput("s5_frozen_out", out_cnt, saved_out);
        applyStimulus(1, 0, 0, 6, 1, 1, 1, 0);
        for (int i = 0; i < 30 && m_phase != P_WAIT; i++) stepCycle();
        ap_done = 1'b1;
        stepCycle();
        ap_done = 1'b0;
        stepCycle();
        stepCycle();

        // Reset while running aborts the job without a completion pulse.
        applyStimulus(1, 1, 0, 8, 1, 1, 0, 0);
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 10 && m_in < 2; i++) stepCycle();
        doReset();
        for (int i = 0; i < 3; i++) stepCycle();

        // Clear while running behaves the same way.
        applyStimulus(1, 1, 0, 8, 1, 1, 0, 0);
        stepCycle();
        start = 1'b0;
        for (int i = 0; i < 10 && m_in < 2; i++) stepCycle();
        clear   = 1'b1;
        flush_k = 1'b1;
        stepCycle();
        clear   = 1'b0;
        flush_k = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle();

        // Randomised jobs with random lengths, enables and handshake patterns.
        for (int j = 0; j < 6; j++) begin
            rlen = $urandom_range(1, 10);
            applyStimulus(1, 1, 0, rlen, 0, 0, 0, 0);
            stepCycle();
            for (int i = 0; i < 400 && m_phase != P_IDLE; i++) begin
                applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1), 0, $urandom,
                              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                              $urandom_range(0, 3) == 0);
                stepCycle();
            end
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            stepCycle();
            #1;
            checkOutput("rand_job_finished", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
